// File: rtl/rr_ticket_arbiter_pkg.sv
// Shared types and defaults for the round-robin ticket arbiter.
// Holds the FSM encoding, default sizes and the index-width helper.
package rr_ticket_arbiter_pkg;

   typedef enum logic {
      StArb = 1'b0,
      StGnt = 1'b1
   } state_e;

   localparam int unsigned DefNReq = 4;
   localparam int unsigned DefW    = 8;
   localparam int unsigned MaxReq  = 16;

   // Width of a requester index; never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_ticket_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above
// the pointer, searching upward modulo N_REQ.
module rr_ticket_arbiter_rr_pick
   import rr_ticket_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned PtrW  = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PtrW-1:0]  ptr_i,
   output logic [N_REQ-1:0] winner_oh_o,
   output logic [PtrW-1:0]  winner_idx_o,
   output logic             any_o
);

   int unsigned idx;

   always_comb begin
      winner_oh_o  = '0;
      winner_idx_o = '0;
      any_o        = 1'b0;
      idx          = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr_i) + k) % N_REQ;
         if (!any_o && req_i[PtrW'(idx)]) begin
            any_o        = 1'b1;
            winner_idx_o = PtrW'(idx);
            winner_oh_o  = N_REQ'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/rr_ticket_arbiter.sv
// Round-robin arbiter handing out tickets from one shared sequence counter.
// Two-state handshake: ARB decides and registers the grant, GNT presents it.
module rr_ticket_arbiter
   import rr_ticket_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   parameter int unsigned W     = DefW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             hold,
   input  logic             clear,
   output logic [N_REQ-1:0] gnt,
   output logic [W-1:0]     ticket,
   output logic             busy,
   output logic             wrap,
   output logic [W-1:0]     count
);

   localparam int unsigned     PtrW    = idx_width(N_REQ);
   localparam logic [PtrW-1:0] LastIdx = PtrW'(N_REQ - 1);

   state_e           state_q, state_d;
   logic [PtrW-1:0]  ptr_q, ptr_d;
   logic [W-1:0]     count_q, count_d;
   logic [W-1:0]     ticket_q, ticket_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             wrap_q, wrap_d;

   logic [N_REQ-1:0] winner_oh;
   logic [PtrW-1:0]  winner_idx;
   logic             any_req;

   rr_ticket_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .PtrW  (PtrW)
   ) u_rr_pick (
      .req_i        (req),
      .ptr_i        (ptr_q),
      .winner_oh_o  (winner_oh),
      .winner_idx_o (winner_idx),
      .any_o        (any_req)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      count_d  = count_q;
      ticket_d = '0;
      gnt_d    = '0;
      wrap_d   = 1'b0;
      unique case (state_q)
         StArb: begin
            if (!hold && any_req) begin
               state_d  = StGnt;
               gnt_d    = winner_oh;
               ticket_d = count_q;
               ptr_d    = (winner_idx == LastIdx) ? '0 : winner_idx + 1'b1;
               count_d  = count_q + 1'b1;
               wrap_d   = (count_q == '1);
            end
         end
         StGnt: begin
            state_d = StArb;
         end
         default: begin
            state_d = StArb;
         end
      endcase
      // Clear wins over the increment and suppresses the wrap pulse.
      if (clear) begin
         count_d = '0;
         wrap_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StArb;
         ptr_q    <= '0;
         count_q  <= '0;
         ticket_q <= '0;
         gnt_q    <= '0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         count_q  <= count_d;
         ticket_q <= ticket_d;
         gnt_q    <= gnt_d;
         wrap_q   <= wrap_d;
      end
   end

   assign gnt    = gnt_q;
   assign ticket = ticket_q;
   assign busy   = (state_q == StGnt);
   assign wrap   = wrap_q;
   assign count  = count_q;

endmodule

// File: tb/tb_rr_ticket_arbiter.sv
// Self-checking bench for rr_ticket_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_rr_ticket_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int Mod = 256;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req = '0;
   logic         hold = 1'b0;
   logic         clear = 1'b0;
   logic [N-1:0] gnt;
   logic [W-1:0] ticket;
   logic         busy;
   logic         wrap;
   logic [W-1:0] count;

   int errors = 0;
   int checks = 0;

   // Behavioural model state.
   int           m_ptr = 0;
   int           m_count = 0;
   bit           m_busy = 0;
   logic [N-1:0] exp_gnt;
   logic [W-1:0] exp_ticket;
   logic         exp_wrap;

   rr_ticket_arbiter #(
      .N_REQ (N),
      .W     (W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .hold   (hold),
      .clear  (clear),
      .gnt    (gnt),
      .ticket (ticket),
      .busy   (busy),
      .wrap   (wrap),
      .count  (count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   // Apply inputs, predict the next edge from the rules, then step past it.
   task automatic drive_edge(input logic [N-1:0] r, input logic h, input logic c);
      int           w;
      int           idx;
      logic [N-1:0] sh;
      req = r;
      hold = h;
      clear = c;
      exp_gnt = '0;
      exp_wrap = 1'b0;
      exp_ticket = '0;
      if (!m_busy && !h && r != '0) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            sh = r >> idx;
            if (w < 0 && sh[0]) w = idx;
         end
         exp_gnt = N'(1) << w;
         exp_ticket = W'(m_count);
         exp_wrap = (m_count == Mod - 1) && !c;
         m_count = c ? 0 : (m_count + 1) % Mod;
         m_ptr = (w + 1) % N;
         m_busy = 1;
      end else begin
         if (c) m_count = 0;
         m_busy = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req = '0;
      hold = 1'b0;
      clear = 1'b0;
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_ptr = 0;
      m_count = 0;
      m_busy = 0;
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      #1;
      checks++;
      if (gnt !== '0 || busy !== 1'b0 || count !== '0 || ticket !== '0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got gnt=%b busy=%b count=%0d ticket=%0d wrap=%b want all 0",
                  gnt, busy, count, ticket, wrap);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_edge('0, 1'b0, 1'b0);
         checks++;
         if (gnt !== '0 || busy !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: cycle %0d got gnt=%b busy=%b count=%0d want 0 0 0",
                     i, gnt, busy, count);
         end
      end
      drive_edge(4'b0100, 1'b0, 1'b0);
      checks++;
      if (gnt !== 4'b0100 || ticket !== 8'd0 || count !== 8'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: got gnt=%b ticket=%0d count=%0d busy=%b want 0100 0 1 1",
                  gnt, ticket, count, busy);
      end
      drive_edge('0, 1'b0, 1'b0);
      checks++;
      if (gnt !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL grant_pulse: got gnt=%b busy=%b want 0000 0", gnt, busy);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] r;
      apply_reset();
      r = 4'b1111;
      for (int i = 0; i < N; i++) begin
         drive_edge(r, 1'b0, 1'b0);
         checks++;
         if (gnt !== (N'(1) << i) || ticket !== W'(i)) begin
            errors++;
            $display("FAIL round_robin: step %0d got gnt=%b ticket=%0d want %b %0d",
                     i, gnt, ticket, N'(1) << i, i);
         end
         r = r & ~gnt;
         drive_edge(r, 1'b0, 1'b0);
         checks++;
         if (gnt !== '0) begin
            errors++;
            $display("FAIL rr_gap: step %0d got gnt=%b want 0000", i, gnt);
         end
      end
   endtask

   task automatic test_fairness();
      int order [5] = '{1, 2, 3, 0, 1};
      drive_edge(4'b0001, 1'b0, 1'b0);
      drive_edge('0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive_edge(4'b1111, 1'b0, 1'b0);
         checks++;
         if (gnt !== (N'(1) << order[i])) begin
            errors++;
            $display("FAIL fairness: step %0d got gnt=%b want %b", i, gnt, N'(1) << order[i]);
         end
         drive_edge(4'b1111, 1'b0, 1'b0);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 255; i++) begin
         drive_edge(4'b0001, 1'b0, 1'b0);
         drive_edge('0, 1'b0, 1'b0);
      end
      checks++;
      if (count !== 8'd255) begin
         errors++;
         $display("FAIL preload: got count=%0d want 255", count);
      end
      drive_edge(4'b0001, 1'b0, 1'b0);
      checks++;
      if (ticket !== 8'd255 || wrap !== 1'b1 || gnt !== 4'b0001 || count !== 8'd0) begin
         errors++;
         $display("FAIL wrap_grant: got ticket=%0d wrap=%b gnt=%b count=%0d want 255 1 0001 0",
                  ticket, wrap, gnt, count);
      end
      drive_edge('0, 1'b0, 1'b0);
      checks++;
      if (wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pulse: got wrap=%b want 0", wrap);
      end
      drive_edge(4'b0001, 1'b0, 1'b0);
      checks++;
      if (ticket !== 8'd0 || count !== 8'd1 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL post_wrap: got ticket=%0d count=%0d wrap=%b want 0 1 0",
                  ticket, count, wrap);
      end
      drive_edge('0, 1'b0, 1'b0);
   endtask

   task automatic test_clear();
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         drive_edge(4'b0001, 1'b0, 1'b0);
         drive_edge('0, 1'b0, 1'b0);
      end
      drive_edge(4'b0010, 1'b0, 1'b1);
      checks++;
      if (ticket !== 8'd7 || gnt !== 4'b0010 || count !== 8'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL clear_with_grant: got ticket=%0d gnt=%b count=%0d wrap=%b want 7 0010 0 0",
                  ticket, gnt, count, wrap);
      end
      drive_edge('0, 1'b0, 1'b0);
      checks++;
      if (count !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_settle: got count=%0d busy=%b want 0 0", count, busy);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         drive_edge(4'b1111, 1'b1, 1'b0);
         checks++;
         if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_blocks: cycle %0d got gnt=%b busy=%b want 0000 0", i, gnt, busy);
         end
      end
      drive_edge(4'b1111, 1'b0, 1'b0);
      checks++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got gnt=%b busy=%b want 0100 1", gnt, busy);
      end
      // Grant is live now; async reset must kill it before the next edge.
      #2 reset = 1'b0;
      #1;
      checks++;
      if (gnt !== '0 || count !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got gnt=%b count=%0d busy=%b want 0000 0 0",
                  gnt, count, busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_ptr = 0;
      m_count = 0;
      m_busy = 0;
   endtask

   task automatic test_random();
      logic [N-1:0] pending;
      logic         h;
      logic         c;
      pending = '0;
      for (int i = 0; i < 600; i++) begin
         h = ($urandom_range(0, 4) == 0);
         c = ($urandom_range(0, 24) == 0);
         drive_edge(pending, h, c);
         checks++;
         if (gnt !== exp_gnt || busy !== m_busy || count !== W'(m_count) || wrap !== exp_wrap) begin
            errors++;
            $display("FAIL random: cycle %0d got gnt=%b busy=%b count=%0d wrap=%b want %b %b %0d %b",
                     i, gnt, busy, count, wrap, exp_gnt, m_busy, m_count, exp_wrap);
         end
         if (exp_gnt != '0) begin
            checks++;
            if (ticket !== exp_ticket) begin
               errors++;
               $display("FAIL random_ticket: cycle %0d got %0d want %0d", i, ticket, exp_ticket);
            end
         end
         pending = (pending & ~gnt) | (N'($urandom) & N'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_fairness();
      test_wrap();
      test_clear();
      test_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_ticket_arbiter.md
Name: rr_ticket_arbiter

Overview:
Shares one W-bit sequence counter among N_REQ requesters, such as NoC router ports or DMA engines that need globally ordered tags.
Grants are issued round-robin through a two-state handshake FSM. Each grant returns the current counter value as a ticket, then the counter advances.
The block sits between local requesters and the shared tag/ordering logic of the NoC interface.

Parameters:
N_REQ, 4, number of requesters (2..16)
W, 8, ticket/counter width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req  input  N_REQ  level request per requester; held high until granted
hold  input  1  freezes arbitration; no new grants while high
clear  input  1  synchronous counter clear to 0
gnt  output  N_REQ  registered one-hot grant, one-cycle pulse
ticket  output  W  ticket value; valid only while |gnt
busy  output  1  high while FSM is in GNT state
wrap  output  1  one-cycle pulse when the counter wraps from 2^W-1 to 0
count  output  W  current counter value, for debug and status

Behaviour:
- Reset (reset=0, async): FSM=ARB, gnt=0, ticket=0, busy=0, wrap=0, count=0, rr pointer=0 (requester 0 has highest priority).
- FSM states: ARB, GNT.
- ARB:
  - if hold=0 and |req: pick the winner, register gnt=onehot(winner), ticket=count, busy=1, go to GNT.
  - else: stay in ARB, gnt=0.
- GNT: gnt/ticket/busy stay valid for exactly this cycle; req is ignored; next state is ARB unconditionally; gnt cleared on exit.
- Latency: req high in ARB cycle t -> gnt high in cycle t+1. Maximum throughput is one grant per 2 cycles.
- Handshake: a requester must drop req at the clock edge ending its gnt cycle. If req is still high in the following ARB cycle, it counts as a new request.
- Round-robin:
  - Search starts at pointer p and runs upward modulo N_REQ; the first asserted req wins.
  - On grant, p <= (winner+1) mod N_REQ.
  - p is unchanged when there is no grant.
- Counter update:
  - Counter increments on the ARB->GNT transition, i.e. at the edge that registers gnt.
  - ticket receives the pre-increment value.
  - Increment is modulo 2^W. At 2^W-1 -> 0, wrap pulses in the same cycle gnt is high.
- clear:
  - count <= 0 at the next edge; takes priority over increment.
  - If clear coincides with a grant decision, the issued ticket is the old count and the counter becomes 0, not 1; wrap is not asserted.
  - clear does not affect the FSM or the pointer.
- hold:
  - Sampled only in ARB.
  - hold rising during GNT does not cancel the current grant.
- Reset mid-GNT: gnt drops immediately (async) and the ticket is lost; requesters must re-request.
- No req, or req=0 in GNT: no effect. gnt is never asserted to a requester whose req was low in the deciding ARB cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ARB=1'b0, GNT=1'b1;
  - default W and N_REQ;
  - an onehot helper constant width.
- One natural sub-module: rr_pick, combinational. Inputs req and pointer; outputs one-hot winner, winner index, and any.
- The counter and FSM stay in the top.

Test Plan:
1. Release reset with req=0 -> gnt=0, count=0, busy=0 for 10 cycles; then pulse req[2] -> gnt=4'b0100 one cycle later, ticket=0, count=1.
2. All four req held high, each dropped after its gnt -> grants in order 0,1,2,3 on alternate cycles, tickets 0,1,2,3.
3. req[1] held permanently high with others also high -> pattern 1,2,3,0,1 (fairness); no requester is starved.
4. Preload via 255 grants (W=8), then a grant -> ticket=255, wrap=1 with gnt, count=0; next grant ticket=0.
5. clear asserted in the same ARB cycle as a grant with count=7 -> ticket=7, count=0 afterwards, wrap=0.
6. hold=1 with req=4'b1111 for 5 cycles -> no gnt; drop hold -> grant next cycle. Also drive reset=0 during GNT -> gnt drops asynchronously and count=0.
